// File: rtl/pixel_buffer_if.sv
// Pixel buffer bus: host write port, fill control, scan-out read and
// out-of-range status. Master is the host/VGA side, slave is the buffer.
interface pixel_buffer_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 15
);
    logic              WR_VALID;
    logic              WR_READY;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              FILL_START;
    logic [DATA_W-1:0] FILL_DATA;
    logic              FILL_BUSY;
    logic              FILL_DONE;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;
    logic              ERR_OOR;
    logic [7:0]        OOR_CNT;

    modport master (
        output WR_VALID, WR_ADDR, WR_DATA, FILL_START, FILL_DATA, RD_ADDR,
        input  WR_READY, FILL_BUSY, FILL_DONE, RD_DATA, ERR_OOR, OOR_CNT
    );

    modport slave (
        input  WR_VALID, WR_ADDR, WR_DATA, FILL_START, FILL_DATA, RD_ADDR,
        output WR_READY, FILL_BUSY, FILL_DONE, RD_DATA, ERR_OOR, OOR_CNT
    );
endinterface

// File: rtl/pixel_buffer_ctrl.sv
// Frame pixel buffer: host writes in IDLE, whole-buffer fill in FILL, and an
// independent registered scan-out read port. Reset doubles as a clear-to-0.
module pixel_buffer_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 32768
) (
    input  logic           VGA_CLK,
    input  logic           VGA_RST,
    pixel_buffer_if.slave  bus
);
    typedef enum logic {IDLE, FILL} state_t;

    localparam int              MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] fill_val_q;
    logic [ADDR_W:0]   fill_cnt_q;   // one spare bit so DEPTH = 2**ADDR_W is unambiguous
    logic [DATA_W-1:0] rd_data_q;
    logic              fill_done_q;
    logic              err_oor_q;
    logic [7:0]        oor_cnt_q;

    logic              wr_in_rng, rd_in_rng, fill_last, wr_acc;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign wr_in_rng = ({1'b0, bus.WR_ADDR} < DEPTH_C);
    assign rd_in_rng = ({1'b0, bus.RD_ADDR} < DEPTH_C);
    assign fill_last = (fill_cnt_q == LAST_C);
    assign wr_acc    = !VGA_RST && (state_q == IDLE) && bus.WR_VALID;

    // State register; reset parks in FILL so the clear starts on release
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) state_q <= FILL;
        else         state_q <= state_d;
    end

    // Next state and memory write-port steering (host in IDLE, fill in FILL)
    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_waddr = bus.WR_ADDR[MEM_AW-1:0];
        mem_wdata = bus.WR_DATA;
        case (state_q)
            IDLE: begin
                mem_we = bus.WR_VALID && wr_in_rng;
                if (bus.FILL_START) state_d = FILL;
            end
            FILL: begin
                mem_we    = 1'b1;
                mem_waddr = fill_cnt_q[MEM_AW-1:0];
                mem_wdata = fill_val_q;
                if (fill_last) state_d = IDLE;
            end
            default: state_d = FILL;
        endcase
        if (VGA_RST) mem_we = 1'b0;
    end

    // Fill value/address: latched on a FILL_START in IDLE, stepped in FILL
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) begin
            fill_val_q <= '0;
            fill_cnt_q <= '0;
        end else if (state_q == IDLE && bus.FILL_START) begin
            fill_val_q <= bus.FILL_DATA;
            fill_cnt_q <= '0;
        end else if (state_q == FILL) begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
        end
    end

    // Memory write port
    always_ff @(posedge VGA_CLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Registered read port; same-address write returns the old word
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST)        rd_data_q <= '0;
        else if (rd_in_rng) rd_data_q <= mem[bus.RD_ADDR[MEM_AW-1:0]];
        else                rd_data_q <= '0;
    end

    // Completion pulse and out-of-range write status
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) begin
            fill_done_q <= 1'b0;
            err_oor_q   <= 1'b0;
            oor_cnt_q   <= '0;
        end else begin
            fill_done_q <= (state_q == FILL) && fill_last;
            err_oor_q   <= wr_acc && !wr_in_rng;
            if (wr_acc && !wr_in_rng && oor_cnt_q != 8'hFF)
                oor_cnt_q <= oor_cnt_q + 8'd1;
        end
    end

    assign bus.WR_READY  = !VGA_RST && (state_q == IDLE);
    assign bus.FILL_BUSY = VGA_RST || (state_q == FILL);
    assign bus.FILL_DONE = fill_done_q;
    assign bus.RD_DATA   = rd_data_q;
    assign bus.ERR_OOR   = err_oor_q;
    assign bus.OOR_CNT   = oor_cnt_q;
endmodule

// File: doc/pixel_buffer_ctrl.md
PIXEL_BUFFER_CTRL -- requirements
Module: pixel_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning pixel width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning pixel address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 32768, meaning pixel count (legal range 2..2**ADDR_W).
REQ-004 The block SHALL have port VGA_CLK  in  1  the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port VGA_RST  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port WR_VALID  in  1  host write request.
REQ-007 The block SHALL have port WR_READY  out  1  write accepted when WR_VALID and WR_READY are both high at a clock edge.
REQ-008 The block SHALL have port WR_ADDR  in  ADDR_W  host write address.
REQ-009 The block SHALL have port WR_DATA  in  DATA_W  host write pixel.
REQ-010 The block SHALL have port FILL_START  in  1  single-cycle request to fill the whole buffer.
REQ-011 The block SHALL have port FILL_DATA  in  DATA_W  fill pixel value.
REQ-012 The block SHALL have port FILL_BUSY  out  1  fill/clear in progress.
REQ-013 The block SHALL have port FILL_DONE  out  1  one-cycle completion pulse.
REQ-014 The block SHALL have port RD_ADDR  in  ADDR_W  scan-out read address from the VGA controller.
REQ-015 The block SHALL have port RD_DATA  out  DATA_W  registered scan-out pixel.
REQ-016 The block SHALL have port ERR_OOR  out  1  one-cycle pulse on an out-of-range accepted write.
REQ-017 The block SHALL have port OOR_CNT  out  8  saturating count of out-of-range writes.

Function
REQ-018 The block SHALL contain a DEPTH x DATA_W memory with one write port and one independent read port.
REQ-019 The block SHALL implement FSM states IDLE and FILL; WR_READY = 1 only in IDLE, FILL_BUSY = 1 only in FILL.
REQ-020 In IDLE, an accepted write with WR_ADDR < DEPTH SHALL store WR_DATA at WR_ADDR on that edge.
REQ-021 An accepted write with WR_ADDR >= DEPTH SHALL be discarded, pulse ERR_OOR on the next cycle, and increment OOR_CNT, saturating at 255.
REQ-022 In IDLE, FILL_START high SHALL latch FILL_DATA, clear the fill address counter to 0, and enter FILL on the next cycle.
REQ-023 In FILL, the block SHALL write the latched value to one address per cycle, ascending 0..DEPTH-1, for exactly DEPTH cycles.
REQ-024 After the write to DEPTH-1, the block SHALL return to IDLE, with FILL_DONE high and WR_READY high in that same first IDLE cycle.
REQ-025 FILL_START asserted while in FILL SHALL be ignored; the fill value and counter are unaffected.
REQ-026 FILL_START and an accepted write in the same IDLE cycle SHALL both take effect: the write is performed, and the subsequent fill overwrites it.
REQ-027 WR_VALID high in FILL SHALL stall without loss; the host holds its request until WR_READY is high.
REQ-028 RD_DATA SHALL be the memory content at the RD_ADDR sampled one cycle earlier (latency 1), and reads SHALL proceed in every state.
REQ-029 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-030 A read with RD_ADDR >= DEPTH SHALL return 0.
REQ-031 The fill address counter SHALL be sized ADDR_W+1 bits so that DEPTH = 2**ADDR_W terminates without wrap ambiguity.

Reset
REQ-032 While VGA_RST is high, the block SHALL force: state = FILL, fill value = 0, fill counter = 0, WR_READY = 0, FILL_BUSY = 1, FILL_DONE = 0, ERR_OOR = 0, OOR_CNT = 0, RD_DATA = 0, and SHALL suppress memory writes.
REQ-033 After VGA_RST falls, the block SHALL perform an automatic clear to 0 per REQ-023/024, ending in a FILL_DONE pulse.
REQ-034 VGA_RST asserted mid-fill or mid-write SHALL abort the operation and restart the clear from address 0.

Verification (DEPTH=16, ADDR_W=5, DATA_W=4)
REQ-035 The bench SHALL cover: release reset -> FILL_BUSY=1 for 16 cycles, FILL_DONE pulse with WR_READY=1 on cycle 17, all RD_DATA reads = 0.
REQ-036 The bench SHALL cover: write 0xA at address 3 in IDLE, then RD_ADDR=3 -> RD_DATA=0xA one cycle later; same-cycle read of address 3 during the write -> 0x0.
REQ-037 The bench SHALL cover: FILL_START with FILL_DATA=0x5, then WR_VALID with address 7 / data 0xF during the fill -> WR_READY=0 until FILL_DONE, then the write completes; address 7 reads 0xF and all other addresses read 0x5.
REQ-038 The bench SHALL cover: write to address 20 -> ERR_OOR pulse and OOR_CNT=1, memory unchanged; 300 such writes -> OOR_CNT=255.
REQ-039 The bench SHALL cover: VGA_RST pulsed at fill cycle 8 -> the clear restarts at address 0 and completes 16 cycles after reset release; OOR_CNT=0.
REQ-040 The bench SHALL cover: FILL_START re-pulsed mid-fill with FILL_DATA=0x9 -> ignored; all addresses hold the original fill value.
